// File: rtl/mem_pkg.sv
// Shared constants and types for the memory bus-cycle sequencer and its lane logic.
package mem_pkg;

    // Memory port width codes (port is 1 << code bytes wide)
    localparam logic [1:0] MW_8  = 2'd0;
    localparam logic [1:0] MW_16 = 2'd1;
    localparam logic [1:0] MW_32 = 2'd2;
    localparam logic [1:0] MW_64 = 2'd3;

    // Transfer sequencer states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Swap lane numbering between little- and big-endian views
    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = v[7-i];
        return r;
    endfunction

endpackage

// File: rtl/mem_cycle_seq_if.sv
// Requester-side and memory-side signals of the bus-cycle sequencer.
// Handshakes: a request is taken on a rising edge where req & req_rdy;
// a bus cycle completes on a rising edge where mem_req & mem_ack, and the
// cycle's outputs hold steady until then. mem_ack without mem_req is ignored.
interface mem_cycle_seq_if #(
    parameter int ADDR_W = 24
);
    logic              req;
    logic [ADDR_W-1:0] req_addr;
    logic [3:0]        req_w;
    logic [1:0]        req_mw;
    logic              req_bigend;
    logic              req_rdy;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_bm;
    logic              mem_last;
    logic              mem_ack;
    logic [2:0]        dofs;
    logic              done;

    // Sequencer side
    modport slave (
        input  req, req_addr, req_w, req_mw, req_bigend, mem_ack,
        output req_rdy, mem_req, mem_addr, mem_bm, mem_last, dofs, done
    );

    // Requester / memory model side
    modport master (
        output req, req_addr, req_w, req_mw, req_bigend, mem_ack,
        input  req_rdy, mem_req, mem_addr, mem_bm, mem_last, dofs, done
    );
endinterface

// File: rtl/mem_lane_calc.sv
// Per-cycle lane math: bytes this cycle can move, the 8-lane byte mask and
// whether this cycle finishes the transfer. Purely combinational so the data
// path can reuse it.
module mem_lane_calc
    import mem_pkg::*;
(
    input  logic [2:0] i_addr_lo,
    input  logic [3:0] i_rem,
    input  logic [1:0] i_mw,
    input  logic       i_bigend,
    output logic [3:0] o_n,
    output logic [7:0] o_bm,
    output logic       o_last
);
    logic [3:0] w_p;
    logic [3:0] w_o;
    logic [3:0] w_room;
    logic [3:0] w_lane;
    logic [3:0] w_end;
    logic [7:0] w_bm_le;

    // Bytes left before the next port-width boundary limit this cycle
    assign w_p    = 4'd1 << i_mw;
    assign w_o    = {1'b0, i_addr_lo} & (w_p - 4'd1);
    assign w_room = w_p - w_o;
    assign o_n    = (i_rem < w_room) ? i_rem : w_room;
    assign w_lane = {1'b0, i_addr_lo};
    // lane + n never exceeds 8 because the window stays inside one aligned port word
    assign w_end  = w_lane + o_n;

    // Contiguous run of lanes starting at the byte lane of the address
    always_comb begin
        w_bm_le = 8'h00;
        for (int i = 0; i < 8; i++) begin
            w_bm_le[i] = (4'(i) >= w_lane) && (4'(i) < w_end);
        end
    end

    assign o_bm   = i_bigend ? bit_rev8(w_bm_le) : w_bm_le;
    assign o_last = (i_rem == o_n);

endmodule

// File: rtl/mem_cycle_seq.sv
// Splits one 1..8 byte transfer into the memory-port bus cycles it needs,
// presenting address, lane mask, last flag and data offset for each cycle.
module mem_cycle_seq
    import mem_pkg::*;
#(
    parameter int ADDR_W    = 24,
    parameter int MAX_BYTES = 8
) (
    input  logic           sys_clk,
    input  logic           resetl,
    mem_cycle_seq_if.slave bus,
    output state_t         o_dbg_state
);
    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [3:0]        r_rem;
    logic [2:0]        r_dofs;
    logic [1:0]        r_mw;
    logic              r_bigend;
    logic              r_req_rdy;
    logic              r_mem_req;
    logic              r_done;

    logic [3:0]        w_n;
    logic [7:0]        w_bm;
    logic              w_last;
    logic [3:0]        w_rem_init;

    // A size of 0 (or anything beyond the largest transfer) means a full transfer
    assign w_rem_init = (bus.req_w == 4'd0 || bus.req_w > 4'(MAX_BYTES))
                        ? 4'(MAX_BYTES) : bus.req_w;

    mem_lane_calc u_lane (
        .i_addr_lo (r_addr[2:0]),
        .i_rem     (r_rem),
        .i_mw      (r_mw),
        .i_bigend  (r_bigend),
        .o_n       (w_n),
        .o_bm      (w_bm),
        .o_last    (w_last)
    );

    // Transfer FSM with the address / remaining / offset registers
    always_ff @(posedge sys_clk or negedge resetl) begin
        if (!resetl) begin
            r_state   <= IDLE;
            r_addr    <= '0;
            r_rem     <= '0;
            r_dofs    <= '0;
            r_mw      <= '0;
            r_bigend  <= 1'b0;
            r_req_rdy <= 1'b1;
            r_mem_req <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (bus.req && r_req_rdy) begin
                        r_addr    <= bus.req_addr;
                        r_rem     <= w_rem_init;
                        r_mw      <= bus.req_mw;
                        r_bigend  <= bus.req_bigend;
                        r_dofs    <= 3'd0;
                        r_req_rdy <= 1'b0;
                        r_mem_req <= 1'b1;
                        r_state   <= RUN;
                    end
                end
                RUN: begin
                    if (bus.mem_ack) begin
                        if (w_last) begin
                            r_mem_req <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= DONE;
                        end else begin
                            r_addr <= r_addr + ADDR_W'(w_n);
                            r_rem  <= r_rem - w_n;
                            r_dofs <= r_dofs + w_n[2:0];
                        end
                    end
                end
                DONE: begin
                    r_done    <= 1'b0;
                    r_req_rdy <= 1'b1;
                    r_state   <= IDLE;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_done    <= 1'b0;
                    r_req_rdy <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

    // Lane outputs only mean something while a bus cycle is being presented
    assign bus.req_rdy  = r_req_rdy;
    assign bus.mem_req  = r_mem_req;
    assign bus.mem_addr = r_addr;
    assign bus.mem_bm   = r_mem_req ? w_bm : 8'h00;
    assign bus.mem_last = r_mem_req & w_last;
    assign bus.dofs     = r_dofs;
    assign bus.done     = r_done;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_mem_cycle_seq.sv
// Directed bench for mem_cycle_seq: drives requests and acks on the falling
// edge and checks every presented bus cycle against hand-derived values.
module tb_mem_cycle_seq;
    import mem_pkg::*;

    logic   sys_clk;
    logic   resetl;
    state_t dbg_state;
    int     n_cmp = 0;
    int     n_err = 0;

    mem_cycle_seq_if #(.ADDR_W(24)) io ();

    mem_cycle_seq #(.ADDR_W(24), .MAX_BYTES(8)) dut (
        .sys_clk     (sys_clk),
        .resetl      (resetl),
        .bus         (io),
        .o_dbg_state (dbg_state)
    );

    // Clock
    initial begin
        sys_clk = 1'b0;
        forever #5 sys_clk = ~sys_clk;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: sim time expired, wanted completion");
        $fatal(1, "watchdog");
    end

    // Drive a request and return on the falling edge after it was taken
    task automatic send_req(input logic [23:0] a, input logic [3:0] w,
                            input logic [1:0] mw, input logic be, input bit hold);
        int t = 0;
        io.req_addr   = a;
        io.req_w      = w;
        io.req_mw     = mw;
        io.req_bigend = be;
        io.req        = 1'b1;
        while (!io.req_rdy && t < 20) begin
            @(negedge sys_clk);
            t++;
        end
        n_cmp++;
        if (io.req_rdy !== 1'b1) begin
            n_err++;
            $display("FAIL accept_wait: req_rdy=%b required 1", io.req_rdy);
        end
        @(negedge sys_clk);
        if (!hold) io.req = 1'b0;
    endtask

    task automatic test_reset();
        logic [38:0] obs, exp_v;
        obs   = {io.req_rdy, io.mem_req, io.mem_last, io.done, io.dofs, io.mem_bm, io.mem_addr};
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 24'h000000};
        n_cmp++;
        if (obs !== exp_v || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL reset_state: got %h st=%0d required %h st=0", obs, dbg_state, exp_v);
        end
    endtask

    // Four directed transfers; up to 3 cycles each, table index = case*3 + cycle
    task automatic test_directed_cases();
        logic [23:0] ca [4] = '{24'h000002, 24'h000003, 24'h000001, 24'hFFFFFE};
        logic [3:0]  cw [4] = '{4'd4, 4'd8, 4'd1, 4'd4};
        logic [1:0]  cm [4] = '{2'd1, 2'd2, 2'd3, 2'd1};
        logic        cb [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        int          cn [4] = '{2, 3, 1, 2};
        logic [23:0] ea [12] = '{24'h000002, 24'h000004, 24'h0,
                                 24'h000003, 24'h000004, 24'h000008,
                                 24'h000001, 24'h0, 24'h0,
                                 24'hFFFFFE, 24'h000000, 24'h0};
        logic [7:0]  eb [12] = '{8'h0C, 8'h30, 8'h00, 8'h08, 8'hF0, 8'h07,
                                 8'h40, 8'h00, 8'h00, 8'hC0, 8'h03, 8'h00};
        logic [2:0]  ed [12] = '{3'd0, 3'd2, 3'd0, 3'd0, 3'd1, 3'd5,
                                 3'd0, 3'd0, 3'd0, 3'd0, 3'd2, 3'd0};
        logic [38:0] obs, exp_v;
        for (int c = 0; c < 4; c++) begin
            send_req(ca[c], cw[c], cm[c], cb[c], 1'b0);
            for (int k = 0; k < cn[c]; k++) begin
                obs   = {io.req_rdy, io.mem_req, io.mem_last, io.done, io.dofs, io.mem_bm, io.mem_addr};
                exp_v = {1'b0, 1'b1, (k == cn[c] - 1), 1'b0, ed[c*3+k], eb[c*3+k], ea[c*3+k]};
                n_cmp++;
                if (obs !== exp_v) begin
                    n_err++;
                    $display("FAIL case%0d_cycle%0d: got %h required %h", c, k, obs, exp_v);
                end
                io.mem_ack = 1'b1;
                @(negedge sys_clk);
                io.mem_ack = 1'b0;
            end
            n_cmp++;
            if ({io.req_rdy, io.mem_req, io.done} !== 3'b001) begin
                n_err++;
                $display("FAIL case%0d_done: rdy/req/done=%b required 001", c,
                         {io.req_rdy, io.mem_req, io.done});
            end
            @(negedge sys_clk);
            n_cmp++;
            if ({io.req_rdy, io.mem_req, io.done} !== 3'b100) begin
                n_err++;
                $display("FAIL case%0d_idle: rdy/req/done=%b required 100", c,
                         {io.req_rdy, io.mem_req, io.done});
            end
        end
    endtask

    // Ack held off 5 clocks with req held high the whole time
    task automatic test_wait_states();
        logic [38:0] obs, exp_v;
        send_req(24'h000002, 4'd4, 2'd1, 1'b0, 1'b1);
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h0C, 24'h000002};
        for (int k = 0; k < 6; k++) begin
            obs = {io.req_rdy, io.mem_req, io.mem_last, io.done, io.dofs, io.mem_bm, io.mem_addr};
            n_cmp++;
            if (obs !== exp_v) begin
                n_err++;
                $display("FAIL wait_hold%0d: got %h required %h", k, obs, exp_v);
            end
            if (k < 5) @(negedge sys_clk);
        end
        io.mem_ack = 1'b1;
        @(negedge sys_clk);
        io.mem_ack = 1'b0;
        obs   = {io.req_rdy, io.mem_req, io.mem_last, io.done, io.dofs, io.mem_bm, io.mem_addr};
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 3'd2, 8'h30, 24'h000004};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL wait_cycle1: got %h required %h", obs, exp_v);
        end
        io.mem_ack = 1'b1;
        @(negedge sys_clk);
        io.mem_ack = 1'b0;
        n_cmp++;
        if ({io.req_rdy, io.mem_req, io.done} !== 3'b001 || dbg_state !== DONE) begin
            n_err++;
            $display("FAIL wait_done_no_accept: rdy/req/done=%b st=%0d required 001 st=2",
                     {io.req_rdy, io.mem_req, io.done}, dbg_state);
        end
        @(negedge sys_clk);
        io.req = 1'b0;
        @(negedge sys_clk);
        n_cmp++;
        if ({io.req_rdy, io.mem_req, io.done} !== 3'b100) begin
            n_err++;
            $display("FAIL wait_idle: rdy/req/done=%b required 100",
                     {io.req_rdy, io.mem_req, io.done});
        end
    endtask

    // Second request offered in the first IDLE cycle after done
    task automatic test_back_to_back();
        logic [38:0] obs, exp_v;
        send_req(24'h000105, 4'd3, 2'd3, 1'b1, 1'b0);
        obs   = {io.req_rdy, io.mem_req, io.mem_last, io.done, io.dofs, io.mem_bm, io.mem_addr};
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 3'd0, 8'h07, 24'h000105};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL b2b_first: got %h required %h", obs, exp_v);
        end
        io.mem_ack = 1'b1;
        @(negedge sys_clk);
        io.mem_ack = 1'b0;
        @(negedge sys_clk);
        send_req(24'h000007, 4'd2, 2'd3, 1'b0, 1'b0);
        obs   = {io.req_rdy, io.mem_req, io.mem_last, io.done, io.dofs, io.mem_bm, io.mem_addr};
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h80, 24'h000007};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL b2b_second_c0: got %h required %h", obs, exp_v);
        end
        io.mem_ack = 1'b1;
        @(negedge sys_clk);
        obs   = {io.req_rdy, io.mem_req, io.mem_last, io.done, io.dofs, io.mem_bm, io.mem_addr};
        exp_v = {1'b0, 1'b1, 1'b1, 1'b0, 3'd1, 8'h01, 24'h000008};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL b2b_second_c1: got %h required %h", obs, exp_v);
        end
        @(negedge sys_clk);
        io.mem_ack = 1'b0;
        n_cmp++;
        if ({io.req_rdy, io.mem_req, io.done} !== 3'b001) begin
            n_err++;
            $display("FAIL b2b_done: rdy/req/done=%b required 001",
                     {io.req_rdy, io.mem_req, io.done});
        end
        @(negedge sys_clk);
    endtask

    // w=0 means 8 bytes on an 8-bit port; reset lands after the first ack
    task automatic test_reset_abort();
        logic [38:0] obs, exp_v;
        int          seen_done = 0;
        send_req(24'h000010, 4'd0, 2'd0, 1'b0, 1'b0);
        obs   = {io.req_rdy, io.mem_req, io.mem_last, io.done, io.dofs, io.mem_bm, io.mem_addr};
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 3'd0, 8'h01, 24'h000010};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL abort_cycle0: got %h required %h", obs, exp_v);
        end
        io.mem_ack = 1'b1;
        @(negedge sys_clk);
        io.mem_ack = 1'b0;
        obs   = {io.req_rdy, io.mem_req, io.mem_last, io.done, io.dofs, io.mem_bm, io.mem_addr};
        exp_v = {1'b0, 1'b1, 1'b0, 1'b0, 3'd1, 8'h02, 24'h000011};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL abort_cycle1: got %h required %h", obs, exp_v);
        end
        #2 resetl = 1'b0;
        #1;
        obs   = {io.req_rdy, io.mem_req, io.mem_last, io.done, io.dofs, io.mem_bm, io.mem_addr};
        exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00, 24'h000000};
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL abort_async_clear: got %h required %h", obs, exp_v);
        end
        @(negedge sys_clk);
        resetl = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge sys_clk);
            if (io.done) seen_done++;
        end
        n_cmp++;
        if ({io.req_rdy, io.mem_req} !== 2'b10 || seen_done != 0 || dbg_state !== IDLE) begin
            n_err++;
            $display("FAIL abort_after_release: rdy/req=%b done_pulses=%0d st=%0d required 10/0/0",
                     {io.req_rdy, io.mem_req}, seen_done, dbg_state);
        end
    endtask

    initial begin
        resetl        = 1'b0;
        io.req        = 1'b0;
        io.req_addr   = '0;
        io.req_w      = '0;
        io.req_mw     = '0;
        io.req_bigend = 1'b0;
        io.mem_ack    = 1'b0;
        repeat (2) @(negedge sys_clk);
        test_reset();
        resetl = 1'b1;
        @(negedge sys_clk);
        test_reset();
        test_directed_cases();
        test_wait_states();
        test_back_to_back();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
